kart_motion: RTL

//  Per-frame kart kinematics stage directly upstream of forward_view.
//  - Once per video frame: samples the steering and pedal inputs.
//  - Updates heading (0..359 deg, 0 = up, i.e. decreasing y) and speed.
//  - Advances the kart's world position on the 2048x2048 track.
//  - Outputs direction/player_x/player_y, which are held stable for the whole frame.

---
 rtl/kart_pkg.sv | 32 +++
 rtl/trig_lut.sv | 25 ++
 rtl/kart_motion.sv | 125 ++++++++++++
 3 files changed

// File: rtl/kart_pkg.sv
// kart_pkg: shared FSM states, fixed-point constants and trig table generator for kart_motion.
package kart_pkg;
    typedef enum logic [2:0] {IDLE, STEER, LOOK0, LOOK1, MOVE, COMMIT} motion_state_t;
    typedef logic [10:0] world_coord_t;
    localparam int TRIG_SHIFT = 9;
    localparam int POS_FRAC = 6;
    localparam logic [16:0] POS_Q_MAX = 17'h1FFFF;
    localparam int DEG_MAX = 360;
    // Elaboration-time round(512 * sin(deg)), half away from zero; Taylor series on [0, 90].
    function automatic logic signed [10:0] trig_val(input int deg);
        int d;
        logic neg;
        real x, term, acc;
        logic signed [10:0] m;
        d = deg % DEG_MAX;
        neg = d >= 180;
        if (neg) d = d - 180;
        if (d > 90) d = 180 - d;
        x = $itor(d) * 3.14159265358979323846 / 180.0;
        term = x;
        acc = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            acc = acc + term;
        end
        m = 11'($rtoi(acc * 512.0 + 0.5));
        return neg ? -m : m;
    endfunction
    function automatic logic [16:0] clamp_pos(input logic signed [18:0] v);
        return v[18] ? 17'd0 : v[17] ? POS_Q_MAX : v[16:0];
    endfunction
endpackage

// File: rtl/trig_lut.sv
// trig_lut: sin/cos of a heading in degrees, signed 11-bit scaled by 512.
// Read-first ROM pair with output register: data appears two clocks after the address.
module trig_lut
    import kart_pkg::*;
(
    input  logic               clk_in,
    input  logic [8:0]         addr,
    output logic signed [10:0] sin_val,
    output logic signed [10:0] cos_val
);
    logic signed [10:0] sin_rom [512];
    logic signed [10:0] cos_rom [512];
    logic [8:0] addr_q;
    for (genvar g = 0; g < 512; g++) begin : g_rom
        localparam logic signed [10:0] S = trig_val(g);
        localparam logic signed [10:0] C = trig_val(g + 90);
        assign sin_rom[g] = S;
        assign cos_rom[g] = C;
    end
    always_ff @(posedge clk_in) begin
        addr_q  <= addr;
        sin_val <= sin_rom[addr_q];
        cos_val <= cos_rom[addr_q];
    end
endmodule

// File: rtl/kart_motion.sv
// kart_motion: per-frame kart heading/speed/position update feeding forward_view.
// Define OFFROAD_SLOW_EN to halve the speed cap while the kart sits on a non-road tile.
module kart_motion
    import kart_pkg::*;
#(
    parameter int START_X   = 1024,
    parameter int START_Y   = 1536,
    parameter int TURN_STEP = 3,
    parameter int ACCEL     = 4,
    parameter int BRAKE     = 8,
    parameter int MAX_SPEED = 255
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_accel,
    input  logic        btn_brake,
    input  logic [3:0]  surface_type,
    output logic [8:0]  direction,
    output logic [10:0] player_x,
    output logic [10:0] player_y,
    output logic [7:0]  speed,
    output logic        busy,
    output logic        update_done
);
    localparam logic [8:0] TURN = 9'(TURN_STEP);
    localparam logic [8:0] SPD_MAX = 9'(MAX_SPEED);
    localparam logic [16:0] START_X_Q = 17'(START_X << POS_FRAC);
    localparam logic [16:0] START_Y_Q = 17'(START_Y << POS_FRAC);

    motion_state_t state_q, state_d;
    logic [8:0] hdg_q, hdg_d, dir_q, dir_d;
    logic [7:0] spd_q, spd_d, spd_out_q, spd_out_d;
    logic [16:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    world_coord_t px_q, px_d, py_q, py_d;
    logic [3:0] btn_q, btn_d;
    logic offroad_q, offroad_d, busy_q, busy_d, done_q, done_d, start;
    logic signed [10:0] sin_val, cos_val;
    logic [9:0] hdg_sum;
    logic [8:0] hdg_l, hdg_r, spd_up, spd_ped, cap;
    logic signed [19:0] spd_s, dx, dy;
    logic signed [18:0] nx, ny;

    // A pulse landing in the trailing busy cycle is dropped, not queued.
    assign start = state_q == IDLE && frame_start && !busy_q;
    assign cap = offroad_q ? SPD_MAX >> 1 : SPD_MAX;
`ifdef OFFROAD_SLOW_EN
    assign offroad_d = start ? surface_type != 4'd0 : offroad_q;
`else
    logic unused_surface;
    assign unused_surface = ^surface_type;
    assign offroad_d = 1'b0;
`endif

    trig_lut u_lut (.clk_in(clk_in), .addr(hdg_q), .sin_val(sin_val), .cos_val(cos_val));

    always_comb begin
        hdg_l = hdg_q >= TURN ? hdg_q - TURN : hdg_q + 9'(DEG_MAX - TURN_STEP);
        hdg_sum = {1'b0, hdg_q} + {1'b0, TURN};
        hdg_r = hdg_sum >= 10'(DEG_MAX) ? 9'(hdg_sum - 10'(DEG_MAX)) : hdg_sum[8:0];
        spd_up = {1'b0, spd_q} + 9'(ACCEL);
        spd_ped = btn_q[0] ? ({1'b0, spd_q} > 9'(BRAKE) ? {1'b0, spd_q} - 9'(BRAKE) : 9'd0)
                : btn_q[1] ? (spd_up > SPD_MAX ? SPD_MAX : spd_up)
                : {1'b0, spd_q - 8'(spd_q != 8'd0)};
        spd_s = 20'(spd_q);
        dx = (spd_s * 20'(sin_val)) >>> TRIG_SHIFT;
        dy = -((spd_s * 20'(cos_val)) >>> TRIG_SHIFT);
        nx = $signed({2'b00, pos_x_q}) + 19'(dx);
        ny = $signed({2'b00, pos_y_q}) + 19'(dy);
        state_d = state_q == IDLE ? (start ? STEER : IDLE)
                : state_q == COMMIT ? IDLE : motion_state_t'(state_q + 3'd1);
        busy_d = state_q != IDLE || start;
        btn_d = start ? {btn_left, btn_right, btn_accel, btn_brake} : btn_q;
        hdg_d = state_q != STEER || btn_q[3] == btn_q[2] ? hdg_q : btn_q[3] ? hdg_l : hdg_r;
        spd_d = state_q != STEER ? spd_q : spd_ped > cap ? cap[7:0] : spd_ped[7:0];
        pos_x_d = state_q == MOVE ? clamp_pos(nx) : pos_x_q;
        pos_y_d = state_q == MOVE ? clamp_pos(ny) : pos_y_q;
        dir_d = state_q == COMMIT ? hdg_q : dir_q;
        spd_out_d = state_q == COMMIT ? spd_q : spd_out_q;
        px_d = state_q == COMMIT ? pos_x_q[16:6] : px_q;
        py_d = state_q == COMMIT ? pos_y_q[16:6] : py_q;
        done_d = state_q == COMMIT;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            hdg_q     <= 9'd0;
            spd_q     <= 8'd0;
            pos_x_q   <= START_X_Q;
            pos_y_q   <= START_Y_Q;
            btn_q     <= 4'd0;
            offroad_q <= 1'b0;
            busy_q    <= 1'b0;
            dir_q     <= 9'd0;
            spd_out_q <= 8'd0;
            px_q      <= START_X_Q[16:6];
            py_q      <= START_Y_Q[16:6];
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdg_q     <= hdg_d;
            spd_q     <= spd_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            btn_q     <= btn_d;
            offroad_q <= offroad_d;
            busy_q    <= busy_d;
            dir_q     <= dir_d;
            spd_out_q <= spd_out_d;
            px_q      <= px_d;
            py_q      <= py_d;
            done_q    <= done_d;
        end
    end

    assign direction = dir_q;
    assign player_x = px_q;
    assign player_y = py_q;
    assign speed = spd_out_q;
    assign busy = busy_q;
    assign update_done = done_q;
endmodule
